ula_arbiter: RTL and testbench
==============================

Name: ula_arbiter

Overview:
- Shares the single ULA (ALU) instance between two requesters, e.g. the main datapath and the branch/address unit.
- Accepts operand/opcode requests over valid/ready handshakes and grants them round-robin.
- Drives the ULA inputs from internal holding registers, waits the configured ULA latency, then returns the result with a requester ID over a valid/ready response channel.
- Sits between the requesters and the ula module. The ULA itself is external and connected through the ula_* ports.

Parameters:
WIDTH, 32, operand/result width (full MIPS word)
OPW, 3, ULA operation-select width
ULA_LAT, 1, number of clock edges after operands are applied before ula_result is valid; 0 means purely combinational ULA

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 accepted this cycle
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_op  input  OPW  requester 0 operation select
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 accepted this cycle
req1_a  input  WIDTH  requester 1 operand A
req1_b  input  WIDTH  requester 1 operand B
req1_op  input  OPW  requester 1 operation select
resp_valid  output  1  result available
resp_ready  input  1  consumer takes result
resp_data  output  WIDTH  captured ULA result
resp_id  output  1  requester that issued the result (0/1)
ula_a  output  WIDTH  to ULA operand A
ula_b  output  WIDTH  to ULA operand B
ula_op  output  OPW  to ULA operation select
ula_result  input  WIDTH  from ULA result
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clock. Reset is asynchronous and active-high.
- Reset values:
  - State is IDLE.
  - resp_valid=0, resp_data=0, resp_id=0.
  - ula_a=0, ula_b=0, ula_op=0, busy=0.
  - last_grant=1, so requester 0 wins the first tie.
  - Wait counter is 0.
- States:
  - IDLE: no operation in flight.
  - ISSUE: operands are on the ULA; waiting ULA_LAT cycles.
  - RESP: result held until consumed.
- Grant (IDLE only, combinational):
  - Only one valid: grant that requester.
  - Both valid: grant the requester != last_grant.
  - None valid: no grant.
- Handshake:
  - reqN_ready=1 only in IDLE and only for the granted N. It is never high for both requesters.
  - It is never high outside IDLE.
- Accept edge (reqN_valid & reqN_ready):
  - Latch reqN_a/b/op into the ula_a/b/op registers.
  - resp_id<=N, last_grant<=N, counter<=0, state->ISSUE.
- ISSUE:
  - ula_a/b/op are held stable for the whole operation.
  - Each edge with counter<ULA_LAT: counter++.
  - On the edge with counter==ULA_LAT: resp_data<=ula_result, state->RESP.
  - ULA_LAT=0 therefore spends exactly one cycle in ISSUE.
- RESP:
  - resp_valid=1; resp_data and resp_id stay stable until accepted.
  - On an edge with resp_ready=1: resp_valid<=0, state->IDLE.
  - resp_ready=0 holds RESP indefinitely (backpressure). No new request is accepted meanwhile.
- Latency: accept at edge E gives resp_valid=1 after edge E+ULA_LAT+1. The earliest next accept is the edge after the response is consumed.
- Throughput: one operation per ULA_LAT+3 cycles with resp_ready held high.
- Requester inputs are sampled only on the accept edge. Changes afterwards have no effect on the operation in flight.
- ula_* outputs keep their last values in IDLE; they are not cleared after an operation.
- The opcode is passed through unmodified. Unsupported ULA codes are not checked here.
- Reset mid-operation (ISSUE or RESP): the operation is dropped with no response, and all registers return to reset values immediately.
- resp_ready high outside RESP is ignored.
- A requester dropping valid before being granted is legal; no state changes.

Test Plan:
- Single request: bench ULA model, ULA_LAT=1, returns a+b for op 3'b010. req0 a=8, b=9, op=3'b010 -> req0_ready pulses once; resp_valid after accept+2 edges; resp_data=17; resp_id=0.
- Tie after reset: req0 and req1 valid in the same cycle (op 3'b010; req0 3+4, req1 10+20) -> req0 served first (resp 7, id 0), then req1 (resp 30, id 1).
- Fairness: both requesters held valid continuously for 6 operations -> grants strictly alternate 0,1,0,1,0,1; ready never high for both requesters in the same cycle.
- Backpressure: resp_ready=0 for 5 cycles during RESP -> resp_valid stays 1; resp_data/resp_id stable; no reqN_ready while held; IDLE one edge after resp_ready=1.
- Operand stability: change req1_a to 0xFFFFFFFF after accept -> ula_a keeps the accepted value until the response; result is unaffected.
- Reset in ISSUE: assert reset asynchronously one cycle after accept -> all outputs 0 and busy=0 immediately; no response emitted; next tie after release grants req0.

Source files
------------

// File: rtl/ula_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ula_arbiter
// Brief    : Round-robin arbiter sharing one external ULA between two
//            requesters, with valid/ready request and response channels.
// Revision : 1.0 - initial release
// ============================================================================
module ula_arbiter #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 3,
  parameter int ULA_LAT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [OPW-1:0]   ula_op,
  input  logic [WIDTH-1:0] ula_result,
  output logic             busy
);

  localparam int c_cnt_w = (ULA_LAT < 1) ? 1 : $clog2(ULA_LAT + 1);
  localparam logic [c_cnt_w-1:0] c_lat = c_cnt_w'(ULA_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_gnt0;
  logic                 w_gnt1;
  logic                 r_last_grant;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_resp_valid;
  logic [WIDTH-1:0]     r_resp_data;
  logic                 r_resp_id;
  logic [WIDTH-1:0]     r_ula_a;
  logic [WIDTH-1:0]     r_ula_b;
  logic [OPW-1:0]       r_ula_op;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Grants are only offered in IDLE; on a tie the requester not served last wins.
  always_comb begin
    w_next_state = r_state;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_gnt0 = req0_valid & (~req1_valid | r_last_grant);
        w_gnt1 = req1_valid & (~req0_valid | ~r_last_grant);
        if (w_gnt0 | w_gnt1) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        if (r_cnt == c_lat) w_next_state = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_id    <= 1'b0;
      r_ula_a      <= '0;
      r_ula_b      <= '0;
      r_ula_op     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0) begin
            r_ula_a      <= req0_a;
            r_ula_b      <= req0_b;
            r_ula_op     <= req0_op;
            r_resp_id    <= 1'b0;
            r_last_grant <= 1'b0;
            r_cnt        <= '0;
          end else if (w_gnt1) begin
            r_ula_a      <= req1_a;
            r_ula_b      <= req1_b;
            r_ula_op     <= req1_op;
            r_resp_id    <= 1'b1;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
          end
        end
        S_ISSUE: begin
          if (r_cnt == c_lat) begin
            r_resp_data  <= ula_result;
            r_resp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) r_resp_valid <= 1'b0;
        end
        default: r_resp_valid <= 1'b0;
      endcase
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_id    = r_resp_id;
  assign ula_a      = r_ula_a;
  assign ula_b      = r_ula_b;
  assign ula_op     = r_ula_op;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ula_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ula_arbiter
// Brief    : Directed-vector bench for ula_arbiter with a 1-cycle ULA model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ula_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        resp_valid, resp_ready, resp_id, busy;
  logic [31:0] resp_data, ula_a, ula_b, ula_result;
  logic [2:0]  ula_op;

  int checks = 0;
  int errors = 0;

  ula_arbiter #(.WIDTH(32), .OPW(3), .ULA_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id),
    .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
    .ula_result(ula_result), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ula_f(input logic [31:0] a, b, input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // One-cycle ULA: result valid one edge after operands are presented.
  always @(posedge clock) ula_result <= ula_f(ula_a, ula_b, ula_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v0;
    logic [31:0] a0, b0;
    logic [2:0]  op0;
    logic        v1;
    logic [31:0] a1, b1;
    logic [2:0]  op1;
    logic [31:0] exp_data;
    logic        exp_id;
  } vec_t;

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Drive one request set, expect it granted to exp_id, check latency and result, consume.
  task automatic run_op(input vec_t v, input string name);
    int n;
    logic got;
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_op = v.op0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_op = v.op1;
    n = 0;
    @(negedge clock);
    while (!(req0_ready || req1_ready) && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({name, " accept_timeout"}, 32'(n < 20), 32'd1);
    if (n >= 20) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    got = req1_ready;
    chk({name, " both_ready"}, 32'(req0_ready & req1_ready), 32'd0);
    chk({name, " grant"}, 32'(got), 32'(v.exp_id));
    @(posedge clock); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 0;
    @(negedge clock);
    while (!resp_valid && n < 20) begin
      @(posedge clock);
      @(negedge clock);
      n++;
    end
    chk({name, " latency"}, 32'(n), 32'd2);
    chk({name, " data"}, resp_data, v.exp_data);
    chk({name, " id"}, 32'(resp_id), 32'(v.exp_id));
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    chk({name, " idle_after"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[8];
  vec_t tv;

  initial begin
    int n, k;
    logic [31:0] held_d;
    logic        held_id;

    vecs[0] = '{1'b1, 32'd8, 32'd9, 3'b010, 1'b0, 32'd0, 32'd0, 3'b000, 32'd17, 1'b0};
    vecs[1] = '{1'b0, 32'd0, 32'd0, 3'b000, 1'b1, 32'd100, 32'd30, 3'b110, 32'd70, 1'b1};
    vecs[2] = '{1'b1, 32'd5, 32'd3, 3'b000, 1'b1, 32'd9, 32'd9, 3'b010, 32'd1, 1'b0};
    vecs[3] = '{1'b1, 32'd1, 32'd2, 3'b010, 1'b1, 32'hF0, 32'h0F, 3'b001, 32'hFF, 1'b1};
    vecs[4] = '{1'b0, 32'd0, 32'd0, 3'b000, 1'b1, 32'd7, 32'd3, 3'b111, 32'd0, 1'b1};
    vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'd1, 3'b010, 1'b1, 32'd1, 32'd1, 3'b010, 32'd0, 1'b0};
    vecs[6] = '{1'b1, 32'd2, 32'd9, 3'b111, 1'b0, 32'd0, 32'd0, 3'b000, 32'd1, 1'b0};
    vecs[7] = '{1'b1, 32'd4, 32'd4, 3'b010, 1'b1, 32'd0, 32'd1, 3'b110, 32'hFFFF_FFFF, 1'b1};

    reset = 1'b1; resp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    #2;
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_data", resp_data, 32'd0);
    chk("rst resp_id", 32'(resp_id), 32'd0);
    chk("rst ula_a", ula_a, 32'd0);
    chk("rst ula_b", ula_b, 32'd0);
    chk("rst ula_op", 32'(ula_op), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: hold the response for 5 cycles with both requesters pending.
    req0_valid = 1'b1; req0_a = 32'd20; req0_b = 32'd22; req0_op = 3'b010;
    n = 0;
    @(negedge clock);
    while (!req0_ready && n < 20) begin @(negedge clock); n++; end
    chk("bp accept_timeout", 32'(n < 20), 32'd1);
    @(posedge clock); #1;
    req1_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!resp_valid && n < 20) begin
      chk("bp ready_in_issue", 32'(req0_ready | req1_ready), 32'd0);
      @(negedge clock);
      n++;
    end
    chk("bp resp_timeout", 32'(resp_valid), 32'd1);
    held_d = resp_data; held_id = resp_id;
    chk("bp data", held_d, 32'd42);
    chk("bp id", 32'(held_id), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("bp valid_held", 32'(resp_valid), 32'd1);
      chk("bp data_held", resp_data, 32'd42);
      chk("bp id_held", 32'(resp_id), 32'd0);
      chk("bp no_ready", 32'(req0_ready | req1_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    chk("bp idle", 32'(busy), 32'd0);
    chk("bp valid_clear", 32'(resp_valid), 32'd0);

    // Operand stability: requester changes its operand after being accepted.
    req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd6; req1_op = 3'b010;
    n = 0;
    @(negedge clock);
    while (!req1_ready && n < 20) begin @(negedge clock); n++; end
    chk("stab accept_timeout", 32'(n < 20), 32'd1);
    @(posedge clock); #1;
    req1_a = 32'hFFFF_FFFF; req1_valid = 1'b0;
    n = 0;
    @(negedge clock);
    while (!resp_valid && n < 20) begin
      chk("stab ula_a", ula_a, 32'd5);
      @(negedge clock);
      n++;
    end
    chk("stab data", resp_data, 32'd11);
    chk("stab id", 32'(resp_id), 32'd1);
    chk("stab ula_a_resp", ula_a, 32'd5);
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;

    // Asynchronous reset one cycle into ISSUE drops the operation.
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_op = 3'b010;
    n = 0;
    @(negedge clock);
    while (!req0_ready && n < 20) begin @(negedge clock); n++; end
    chk("rsti accept_timeout", 32'(n < 20), 32'd1);
    @(posedge clock); #1;
    req0_valid = 1'b0;
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    chk("rsti busy", 32'(busy), 32'd0);
    chk("rsti resp_valid", 32'(resp_valid), 32'd0);
    chk("rsti resp_data", resp_data, 32'd0);
    chk("rsti resp_id", 32'(resp_id), 32'd0);
    chk("rsti ula_a", ula_a, 32'd0);
    chk("rsti ula_b", ula_b, 32'd0);
    chk("rsti ula_op", 32'(ula_op), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (resp_valid || busy) k++;
    end
    chk("rsti no_response", 32'(k), 32'd0);
    @(posedge clock); #1;
    tv = '{1'b1, 32'd3, 32'd4, 3'b010, 1'b1, 32'd10, 32'd20, 3'b010, 32'd7, 1'b0};
    run_op(tv, "tie0");
    tv.exp_data = 32'd30; tv.exp_id = 1'b1;
    run_op(tv, "tie1");

    // Fairness: both requesters continuously valid, consumer always ready.
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b010;
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_op = 3'b010;
    resp_ready = 1'b1;
    k = 0; n = 0;
    while (k < 6 && n < 80) begin
      @(negedge clock);
      if (req0_ready || req1_ready) begin
        chk("fair both_ready", 32'(req0_ready & req1_ready), 32'd0);
        chk($sformatf("fair grant%0d", k), 32'(req1_ready), 32'(k % 2));
        k++;
      end
      n++;
    end
    chk("fair grant_count", 32'(k), 32'd6);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (6) @(posedge clock);
    resp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
